// File: rtl/id_ex_if.sv
// ID-to-EX pipeline bus: decoded instruction, operands and control in; registered EX copy,
// stall request and bubble statistics out.
interface id_ex_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm_ext;
    logic        id_RegDst;
    logic        id_Branch;
    logic        id_MemtoReg;
    logic        id_MemWrite;
    logic        id_ALUSrc;
    logic        id_RegWrite;
    logic        id_Jump;
    logic        id_Ext_op;
    logic [3:0]  id_ALUOp;
    logic        flush;

    logic        ex_valid;
    logic [31:0] ex_pc_plus4;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm_ext;
    logic        ex_RegDst;
    logic        ex_Branch;
    logic        ex_MemtoReg;
    logic        ex_MemWrite;
    logic        ex_ALUSrc;
    logic        ex_RegWrite;
    logic        ex_Jump;
    logic        ex_Ext_op;
    logic [3:0]  ex_ALUOp;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_shamt;
    logic [5:0]  ex_funct;
    logic        stall;
    logic [15:0] bubble_cnt;

    modport master (
        output id_valid, id_instr, id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
               id_RegDst, id_Branch, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite,
               id_Jump, id_Ext_op, id_ALUOp, flush,
        input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_RegDst, ex_Branch, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
               ex_Jump, ex_Ext_op, ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct,
               stall, bubble_cnt
    );

    modport slave (
        input  id_valid, id_instr, id_pc_plus4, id_rs_data, id_rt_data, id_imm_ext,
               id_RegDst, id_Branch, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite,
               id_Jump, id_Ext_op, id_ALUOp, flush,
        output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm_ext,
               ex_RegDst, ex_Branch, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite,
               ex_Jump, ex_Ext_op, ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct,
               stall, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Latency: one cycle ID->EX; stall is combinational in the same cycle.
// Backpressure: stall freezes PC/IF-ID while a bubble is loaded; flush overrides stall.
module id_ex_stage (
    input  logic  clk,
    input  logic  rst_n,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_plus4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic        reg_dst;
        logic        branch;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic        jump;
        logic        ext_op;
        logic [3:0]  alu_op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
    } ex_reg_t;

    ex_reg_t     ex_q;
    ex_reg_t     ex_d;
    logic [15:0] bubble_cnt_q;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        rt_is_read;
    logic        load_use;
    logic        counted_bubble;
    logic        unused_opcode;

    assign id_rs         = bus.id_instr[25:21];
    assign id_rt         = bus.id_instr[20:16];
    assign unused_opcode = ^bus.id_instr[31:26];

    // rt is only a true source for R-type ALU ops and for stores (store data).
    assign rt_is_read = ~bus.id_ALUSrc | bus.id_MemWrite;

    assign load_use = ex_q.valid & ex_q.mem_to_reg & (ex_q.rt != 5'd0) & bus.id_valid &
                      ((ex_q.rt == id_rs) | ((ex_q.rt == id_rt) & rt_is_read));

    assign bus.stall    = load_use & ~bus.flush;
    assign counted_bubble = bus.flush | load_use;

    always_comb begin
        ex_d = '0;
        if (!counted_bubble && bus.id_valid) begin
            ex_d.valid      = 1'b1;
            ex_d.pc_plus4   = bus.id_pc_plus4;
            ex_d.rs_data    = bus.id_rs_data;
            ex_d.rt_data    = bus.id_rt_data;
            ex_d.imm_ext    = bus.id_imm_ext;
            ex_d.reg_dst    = bus.id_RegDst;
            ex_d.branch     = bus.id_Branch;
            ex_d.mem_to_reg = bus.id_MemtoReg;
            ex_d.mem_write  = bus.id_MemWrite;
            ex_d.alu_src    = bus.id_ALUSrc;
            ex_d.reg_write  = bus.id_RegWrite;
            ex_d.jump       = bus.id_Jump;
            ex_d.ext_op     = bus.id_Ext_op;
            ex_d.alu_op     = bus.id_ALUOp;
            ex_d.rs         = id_rs;
            ex_d.rt         = id_rt;
            ex_d.rd         = bus.id_instr[15:11];
            ex_d.shamt      = bus.id_instr[10:6];
            ex_d.funct      = bus.id_instr[5:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= 16'd0;
        end else begin
            ex_q <= ex_d;
            if (counted_bubble && (bubble_cnt_q != 16'hFFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc_plus4 = ex_q.pc_plus4;
    assign bus.ex_rs_data  = ex_q.rs_data;
    assign bus.ex_rt_data  = ex_q.rt_data;
    assign bus.ex_imm_ext  = ex_q.imm_ext;
    assign bus.ex_RegDst   = ex_q.reg_dst;
    assign bus.ex_Branch   = ex_q.branch;
    assign bus.ex_MemtoReg = ex_q.mem_to_reg;
    assign bus.ex_MemWrite = ex_q.mem_write;
    assign bus.ex_ALUSrc   = ex_q.alu_src;
    assign bus.ex_RegWrite = ex_q.reg_write;
    assign bus.ex_Jump     = ex_q.jump;
    assign bus.ex_Ext_op   = ex_q.ext_op;
    assign bus.ex_ALUOp    = ex_q.alu_op;
    assign bus.ex_rs       = ex_q.rs;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_shamt    = ex_q.shamt;
    assign bus.ex_funct    = ex_q.funct;
    assign bus.bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, load-use stall, $zero, flush priority,
// bubble counter saturation and asynchronous reset.
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    id_ex_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ctrl = {RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, Ext_op}
    task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] imm,
                         input logic [7:0] ctrl, input logic [3:0] aluop, input logic fl);
        bus.id_valid    = vld;
        bus.id_instr    = instr;
        bus.id_pc_plus4 = 32'h0000_0400 ^ instr;
        bus.id_rs_data  = 32'hA5A5_0000 | {27'd0, instr[25:21]};
        bus.id_rt_data  = 32'h5A5A_0000 | {27'd0, instr[20:16]};
        bus.id_imm_ext  = imm;
        {bus.id_RegDst, bus.id_Branch, bus.id_MemtoReg, bus.id_MemWrite,
         bus.id_ALUSrc, bus.id_RegWrite, bus.id_Jump, bus.id_Ext_op} = ctrl;
        bus.id_ALUOp    = aluop;
        bus.flush       = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI_T1  = 32'h2109_0005; // addi $t1,$t0,5
    localparam logic [31:0] LW_T0    = 32'h8E08_0000; // lw $t0,0($s0)
    localparam logic [31:0] ADD_T2   = 32'h0109_5020; // add $t2,$t0,$t1
    localparam logic [31:0] LW_ZERO  = 32'h8C00_0000; // lw $zero,0($zero)
    localparam logic [31:0] ADD_ZERO = 32'h0000_5020; // add $t2,$zero,$zero
    localparam logic [31:0] ADDI_RT8 = 32'h2128_0005; // addi $t0,$t1,5
    localparam logic [31:0] SW_T0    = 32'hAD28_0000; // sw $t0,0($t1)

    localparam logic [7:0] C_ADDI = 8'b0000_1101;
    localparam logic [7:0] C_LW   = 8'b0010_1101;
    localparam logic [7:0] C_RTYP = 8'b1000_0100;
    localparam logic [7:0] C_SW   = 8'b0001_1001;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 8'd0, 4'd0, 1'b0);

        // Reset state
        #3;
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        step();
        rst_n = 1'b1;

        // Pass-through of addi
        drive(1'b1, ADDI_T1, 32'd5, C_ADDI, 4'b0000, 1'b0);
        check("pt_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check("pt_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("pt_ex_aluop", {28'd0, bus.ex_ALUOp}, 32'd0);
        check("pt_ex_imm", bus.ex_imm_ext, 32'd5);
        check("pt_ex_rt", {27'd0, bus.ex_rt}, 32'd9);
        check("pt_ex_rs", {27'd0, bus.ex_rs}, 32'd8);
        check("pt_ex_funct", {26'd0, bus.ex_funct}, 32'd5);
        check("pt_ex_regwrite", {31'd0, bus.ex_RegWrite}, 32'd1);
        check("pt_ex_alusrc", {31'd0, bus.ex_ALUSrc}, 32'd1);
        check("pt_ex_pc4", bus.ex_pc_plus4, 32'h2109_0405);
        check("pt_ex_rs_data", bus.ex_rs_data, 32'hA5A5_0008);
        check("pt_stall_after", {31'd0, bus.stall}, 32'd0);

        // Load-use: lw $t0 in EX, add $t2,$t0,$t1 in ID
        drive(1'b1, LW_T0, 32'd0, C_LW, 4'b0000, 1'b0);
        step();
        check("lu_ex_memtoreg", {31'd0, bus.ex_MemtoReg}, 32'd1);
        drive(1'b1, ADD_T2, 32'h0000_5020, C_RTYP, 4'b0010, 1'b0);
        check("lu_stall", {31'd0, bus.stall}, 32'd1);
        step();
        check("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("lu_bubble_regwrite", {31'd0, bus.ex_RegWrite}, 32'd0);
        check("lu_bubble_rt", {27'd0, bus.ex_rt}, 32'd0);
        check("lu_bubble_cnt", {16'd0, bus.bubble_cnt}, 32'd1);
        check("lu_stall_cleared", {31'd0, bus.stall}, 32'd0);
        step();
        check("lu_add_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("lu_add_rd", {27'd0, bus.ex_rd}, 32'd10);
        check("lu_add_funct", {26'd0, bus.ex_funct}, 32'h20);
        check("lu_add_aluop", {28'd0, bus.ex_ALUOp}, 32'd2);
        check("lu_add_cnt", {16'd0, bus.bubble_cnt}, 32'd1);

        // $zero destination never stalls
        drive(1'b1, LW_ZERO, 32'd0, C_LW, 4'b0000, 1'b0);
        step();
        drive(1'b1, ADD_ZERO, 32'h0000_5020, C_RTYP, 4'b0010, 1'b0);
        check("zero_stall", {31'd0, bus.stall}, 32'd0);
        step();

        // rt of an immediate op is not a source
        drive(1'b1, LW_T0, 32'd0, C_LW, 4'b0000, 1'b0);
        step();
        drive(1'b1, ADDI_RT8, 32'd5, C_ADDI, 4'b0000, 1'b0);
        check("imm_rt_stall", {31'd0, bus.stall}, 32'd0);

        // Store reads rt as data: stall, unless flushed
        drive(1'b1, SW_T0, 32'd0, C_SW, 4'b0000, 1'b0);
        check("sw_rt_stall", {31'd0, bus.stall}, 32'd1);
        drive(1'b1, SW_T0, 32'd0, C_SW, 4'b0000, 1'b1);
        check("flush_stall", {31'd0, bus.stall}, 32'd0);
        step();
        check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("flush_memwrite", {31'd0, bus.ex_MemWrite}, 32'd0);
        check("flush_cnt", {16'd0, bus.bubble_cnt}, 32'd2);

        // Idle bubble is not counted
        drive(1'b0, ADDI_T1, 32'd5, C_ADDI, 4'b0000, 1'b0);
        step();
        check("idle_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("idle_cnt", {16'd0, bus.bubble_cnt}, 32'd2);

        // Saturation: 65533 more flushes reach 0xFFFF, one more stays there
        drive(1'b1, ADDI_T1, 32'd5, C_ADDI, 4'b0000, 1'b1);
        for (int i = 0; i < 65532; i++) begin
            @(posedge clk);
        end
        #1;
        check("sat_near", {16'd0, bus.bubble_cnt}, 32'h0000_FFFE);
        step();
        check("sat_reach", {16'd0, bus.bubble_cnt}, 32'h0000_FFFF);
        step();
        check("sat_hold", {16'd0, bus.bubble_cnt}, 32'h0000_FFFF);

        // Asynchronous reset between edges
        drive(1'b1, ADDI_T1, 32'd5, C_ADDI, 4'b0000, 1'b0);
        step();
        check("ar_pre_valid", {31'd0, bus.ex_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("ar_cnt", {16'd0, bus.bubble_cnt}, 32'd0);
        check("ar_imm", bus.ex_imm_ext, 32'd0);
        check("ar_regwrite", {31'd0, bus.ex_RegWrite}, 32'd0);
        check("ar_stall", {31'd0, bus.stall}, 32'd0);
        #1;
        rst_n = 1'b1;
        step();
        check("ar_recover_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("ar_recover_rt", {27'd0, bus.ex_rt}, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 id_valid  input  1  ID stage holds a live instruction.
REQ-005 id_instr  input  32  ID instruction word; rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
REQ-006 id_pc_plus4  input  32  PC+4 of the ID instruction.
REQ-007 id_rs_data, id_rt_data, id_imm_ext  input  32 each  register-file read data and extended immediate.
REQ-008 id_RegDst, id_Branch, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite, id_Jump, id_Ext_op  input  1 each  decoder control bits.
REQ-009 id_ALUOp  input  4  decoder ALU operation code.
REQ-010 flush  input  1  branch/jump resolution kills the ID instruction.
REQ-011 ex_* outputs  output  same widths as REQ-006..REQ-009  registered copies; also ex_rs, ex_rt, ex_rd, ex_shamt (5 each), ex_funct (6).
REQ-012 ex_valid  output  1  EX stage holds a live instruction.
REQ-013 stall  output  1  combinational; freeze PC and IF/ID register this cycle.
REQ-014 bubble_cnt  output  16  saturating count of bubbles inserted.

Function
REQ-015 load_use SHALL be ex_valid & ex_MemtoReg & (ex_rt != 0) & id_valid & ((ex_rt == id rs) | ((ex_rt == id rt) & (~id_ALUSrc | id_MemWrite))).
REQ-016 stall SHALL equal load_use & ~flush; no register delay.
REQ-017 Each rising edge, priority: flush, then load_use, then id_valid.
REQ-018 flush=1: load bubble (all ex_ control bits 0, ex_valid 0, all data/field outputs 0).
REQ-019 flush=0, load_use=1: load bubble as REQ-018; the ID instruction is held upstream and re-presented next cycle.
REQ-020 flush=0, load_use=0, id_valid=1: capture all id_ inputs and instruction fields, ex_valid=1, one-cycle latency.
REQ-021 flush=0, load_use=0, id_valid=0: load bubble as REQ-018.
REQ-022 A bubble SHALL never assert ex_RegWrite, ex_MemWrite, ex_Branch or ex_Jump.
REQ-023 bubble_cnt SHALL increment by 1 on every edge where REQ-018 or REQ-019 applies, saturating at 16'hFFFF (no wrap); REQ-021 bubbles are not counted.
REQ-024 Two consecutive loads feeding a dependent: stall SHALL last exactly one cycle per load-use pair, since the bubble clears ex_MemtoReg.
REQ-025 rt == 0 (register $zero) SHALL never cause a stall.

Reset
REQ-026 rst_n low SHALL immediately (without clk) clear every ex_ output, ex_valid and bubble_cnt to 0; stall then evaluates to 0.
REQ-027 Reset asserted mid-operation SHALL discard the captured instruction; the first edge after rst_n rises follows REQ-017 normally.

Verification
REQ-028 Pass-through: id_valid=1, addi $t1,$t0,5 (ALUSrc=1, RegWrite=1, ALUOp=0000), imm 5 -> next edge ex_valid=1, ex_ALUOp=0000, ex_imm_ext=5, ex_rt=9, stall=0.
REQ-029 Load-use: EX holds lw $t0 (ex_rt=8, MemtoReg=1); ID add $t2,$t0,$t1 -> stall=1 that cycle, next edge bubble (ex_valid=0), bubble_cnt=1; following cycle stall=0 and add captured.
REQ-030 $zero/immaterial rt: EX lw to rt=0 with ID using rs=0 -> stall=0; EX lw rt=8 with ID addi rt=8, rs=9 -> stall=0.
REQ-031 Flush priority: load_use condition true and flush=1 same cycle -> stall=0, bubble loaded, bubble_cnt+1.
REQ-032 Saturation: force 65535 counted bubbles, then one more -> bubble_cnt stays 16'hFFFF.
REQ-033 Async reset: valid instruction in EX, drop rst_n between edges -> all outputs 0 before next edge, bubble_cnt=0.
